// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: CPU fetch port, CPU load/store port and
// the single-port memory side. The arbiter uses the slave view and the
// CPU/memory environment uses the master view.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic [ADDR_W-1:0] fetch_addr;
   logic              fetch_rd;
   logic              fetch_wait;
   logic [DATA_W-1:0] fetch_rddata;
   logic              fetch_rdvalid;

   logic [ADDR_W-1:0] ldst_addr;
   logic              ldst_rd;
   logic              ldst_wr;
   logic [DATA_W-1:0] ldst_wrdata;
   logic              ldst_wait;
   logic [DATA_W-1:0] ldst_rddata;
   logic              ldst_rdvalid;

   logic [ADDR_W-1:0] m_addr;
   logic              m_rd;
   logic              m_wr;
   logic [DATA_W-1:0] m_wrdata;
   logic [DATA_W-1:0] m_rddata;

   modport slave (
      input  fetch_addr, fetch_rd, ldst_addr, ldst_rd, ldst_wr, ldst_wrdata, m_rddata,
      output fetch_wait, fetch_rddata, fetch_rdvalid,
      output ldst_wait, ldst_rddata, ldst_rdvalid,
      output m_addr, m_rd, m_wr, m_wrdata
   );

   modport master (
      output fetch_addr, fetch_rd, ldst_addr, ldst_rd, ldst_wr, ldst_wrdata, m_rddata,
      input  fetch_wait, fetch_rddata, fetch_rdvalid,
      input  ldst_wait, ldst_rddata, ldst_rdvalid,
      input  m_addr, m_rd, m_wr, m_wrdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// Load/store normally wins; a run counter hands the port to fetch after
// MAX_LDST_RUN back-to-back load/store grants. Reads are tagged with their
// owner in a RD_LATENCY-deep pipe so returning data reaches the right port.
module mem_port_arbiter #(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 16,
   parameter int RD_LATENCY   = 1,
   parameter int MAX_LDST_RUN = 4
) (
   input logic clk,
   input logic reset,
   mem_port_arbiter_if.slave bus
);

   localparam logic [3:0] RUN_LIMIT = 4'(MAX_LDST_RUN);

   logic [3:0]            run_cnt;
   logic                  ldst_req;
   logic                  fetch_grant;
   logic                  ldst_grant;
   logic                  rd_grant;
   logic [RD_LATENCY-1:0] pipe_valid;
   logic [RD_LATENCY-1:0] pipe_owner;
   logic                  ret_valid;
   logic                  ret_fetch;
   logic [DATA_W-1:0]     fetch_hold;
   logic [DATA_W-1:0]     ldst_hold;

   // Pick at most one port per cycle; nothing is granted while reset is high.
   always_comb begin
      ldst_req    = bus.ldst_rd | bus.ldst_wr;
      fetch_grant = 1'b0;
      ldst_grant  = 1'b0;
      if (!reset) begin
         if (bus.fetch_rd && ldst_req) begin
            if (run_cnt == RUN_LIMIT) fetch_grant = 1'b1;
            else                      ldst_grant  = 1'b1;
         end else begin
            fetch_grant = bus.fetch_rd;
            ldst_grant  = ldst_req;
         end
      end
   end

   // Drive the memory from the granted port; a combined rd+wr is a write.
   always_comb begin
      bus.m_addr   = {ADDR_W{1'b0}};
      bus.m_rd     = 1'b0;
      bus.m_wr     = 1'b0;
      bus.m_wrdata = {DATA_W{1'b0}};
      if (fetch_grant) begin
         bus.m_addr = bus.fetch_addr;
         bus.m_rd   = 1'b1;
      end else if (ldst_grant) begin
         bus.m_addr = bus.ldst_addr;
         if (bus.ldst_wr) begin
            bus.m_wr     = 1'b1;
            bus.m_wrdata = bus.ldst_wrdata;
         end else begin
            bus.m_rd = 1'b1;
         end
      end
   end

   assign rd_grant      = fetch_grant | (ldst_grant & ~bus.ldst_wr);
   assign bus.fetch_wait = bus.fetch_rd & ~fetch_grant;
   assign bus.ldst_wait  = ldst_req & ~ldst_grant;

   // Count load/store grants that kept fetch waiting; any fetch grant or idle fetch restarts it.
   always_ff @(posedge clk) begin
      if (reset || fetch_grant || !bus.fetch_rd) begin
         run_cnt <= 4'd0;
      end else if (ldst_grant && run_cnt != RUN_LIMIT) begin
         run_cnt <= run_cnt + 4'd1;
      end
   end

   // Shift read tags toward the return point; reset kills every read in flight.
   always_ff @(posedge clk) begin
      pipe_owner[0] <= fetch_grant;
      for (int i = 1; i < RD_LATENCY; i++) begin
         pipe_owner[i] <= pipe_owner[i-1];
      end
      if (reset) begin
         pipe_valid <= '0;
      end else begin
         pipe_valid[0] <= rd_grant;
         for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
         end
      end
   end

   assign ret_valid         = ~reset & pipe_valid[RD_LATENCY-1];
   assign ret_fetch         = pipe_owner[RD_LATENCY-1];
   assign bus.fetch_rdvalid = ret_valid & ret_fetch;
   assign bus.ldst_rdvalid  = ret_valid & ~ret_fetch;
   assign bus.fetch_rddata  = bus.fetch_rdvalid ? bus.m_rddata : fetch_hold;
   assign bus.ldst_rddata   = bus.ldst_rdvalid  ? bus.m_rddata : ldst_hold;

   // Keep the last returned word per port so rddata stays stable between returns.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_hold <= {DATA_W{1'b0}};
         ldst_hold  <= {DATA_W{1'b0}};
      end else begin
         if (bus.fetch_rdvalid) fetch_hold <= bus.m_rddata;
         if (bus.ldst_rdvalid)  ldst_hold  <= bus.m_rddata;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: two instances (read latency 1 and 3) share
// one randomized CPU stimulus, each with its own random memory data, and are
// compared every cycle against a calendar-based reference model.
module tb_mem_port_arbiter;

   localparam int AW      = 16;
   localparam int DW      = 16;
   localparam int MAX_RUN = 4;
   localparam int NCYC    = 1200;

   typedef struct packed {
      logic        fw, lw, mrd, mwr, fv, lv;
      logic [15:0] maddr, mwd, frd, lrd;
   } obs_t;

   logic clk = 1'b0;
   logic reset;
   logic [15:0] fetch_addr, ldst_addr, ldst_wrdata;
   logic fetch_rd, ldst_rd, ldst_wr;
   logic [15:0] mem_data [2];
   obs_t obs [2];

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   int streak = 0;
   int lat [2] = '{1, 3};
   bit cal_valid [2][16];
   bit cal_fetch [2][16];
   logic [15:0] hold_f [2];
   logic [15:0] hold_l [2];
   bit prev_fw = 1'b0;
   bit prev_lw = 1'b0;

   // Free-running clock.
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1), .MAX_LDST_RUN(MAX_RUN))
      dut_a (.clk(clk), .reset(reset), .bus(bus_a));
   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(3), .MAX_LDST_RUN(MAX_RUN))
      dut_b (.clk(clk), .reset(reset), .bus(bus_b));

   assign bus_a.fetch_addr  = fetch_addr;
   assign bus_a.fetch_rd    = fetch_rd;
   assign bus_a.ldst_addr   = ldst_addr;
   assign bus_a.ldst_rd     = ldst_rd;
   assign bus_a.ldst_wr     = ldst_wr;
   assign bus_a.ldst_wrdata = ldst_wrdata;
   assign bus_a.m_rddata    = mem_data[0];
   assign bus_b.fetch_addr  = fetch_addr;
   assign bus_b.fetch_rd    = fetch_rd;
   assign bus_b.ldst_addr   = ldst_addr;
   assign bus_b.ldst_rd     = ldst_rd;
   assign bus_b.ldst_wr     = ldst_wr;
   assign bus_b.ldst_wrdata = ldst_wrdata;
   assign bus_b.m_rddata    = mem_data[1];

   assign obs[0] = {bus_a.fetch_wait, bus_a.ldst_wait, bus_a.m_rd, bus_a.m_wr,
                    bus_a.fetch_rdvalid, bus_a.ldst_rdvalid, bus_a.m_addr, bus_a.m_wrdata,
                    bus_a.fetch_rddata, bus_a.ldst_rddata};
   assign obs[1] = {bus_b.fetch_wait, bus_b.ldst_wait, bus_b.m_rd, bus_b.m_wr,
                    bus_b.fetch_rdvalid, bus_b.ldst_rdvalid, bus_b.m_addr, bus_b.m_wrdata,
                    bus_b.fetch_rddata, bus_b.ldst_rddata};

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // mode 0: random mix, 1: both ports always requesting, 2: fetch only, 3: idle.
   // A port that was told to wait keeps its request unchanged.
   task automatic applyStimulus(input int mode);
      if (!prev_fw) begin
         fetch_addr = 16'($urandom);
         case (mode)
            0:       fetch_rd = ($urandom_range(0, 1) == 1);
            1, 2:    fetch_rd = 1'b1;
            default: fetch_rd = 1'b0;
         endcase
      end
      if (!prev_lw) begin
         ldst_addr   = 16'($urandom);
         ldst_wrdata = 16'($urandom);
         case (mode)
            0: begin
               ldst_rd = ($urandom_range(0, 1) == 1);
               ldst_wr = ($urandom_range(0, 3) == 0);
            end
            1: begin
               ldst_wr = ($urandom_range(0, 2) == 0);
               ldst_rd = !ldst_wr || ($urandom_range(0, 1) == 1);
            end
            default: begin
               ldst_rd = 1'b0;
               ldst_wr = 1'b0;
            end
         endcase
      end
      mem_data[0] = 16'($urandom);
      mem_data[1] = 16'($urandom);
   endtask

   // Evaluate the reference for the current cycle, compare both DUTs, then advance to the next edge.
   task automatic modelCycle();
      bit fr, lr, wr, fg, lg, exp_fw, exp_lw, exp_mrd, exp_mwr, ef, el;
      logic [15:0] exp_maddr, exp_mwd, exp_frd, exp_lrd;
      int slot;
      string nm;
      fr = fetch_rd;
      lr = ldst_rd || ldst_wr;
      wr = ldst_wr;
      fg = 1'b0;
      lg = 1'b0;
      if (!reset) begin
         if (fr && lr) begin
            if (streak >= MAX_RUN) fg = 1'b1;
            else                   lg = 1'b1;
         end else begin
            fg = fr;
            lg = lr;
         end
      end
      exp_fw    = fr && !fg;
      exp_lw    = lr && !lg;
      exp_mrd   = fg || (lg && !wr);
      exp_mwr   = lg && wr;
      exp_maddr = fg ? fetch_addr : (lg ? ldst_addr : 16'h0000);
      exp_mwd   = (lg && wr) ? ldst_wrdata : 16'h0000;
      slot      = cyc % 16;
      for (int k = 0; k < 2; k++) begin
         nm = (k == 0) ? "lat1" : "lat3";
         checkOutput({nm, ".fetch_wait"}, 32'(obs[k].fw), 32'(exp_fw));
         checkOutput({nm, ".ldst_wait"}, 32'(obs[k].lw), 32'(exp_lw));
         checkOutput({nm, ".m_rd"}, 32'(obs[k].mrd), 32'(exp_mrd));
         checkOutput({nm, ".m_wr"}, 32'(obs[k].mwr), 32'(exp_mwr));
         if (reset) begin
            checkOutput({nm, ".fetch_rdvalid"}, 32'(obs[k].fv), 32'd0);
            checkOutput({nm, ".ldst_rdvalid"}, 32'(obs[k].lv), 32'd0);
         end else begin
            checkOutput({nm, ".m_addr"}, 32'(obs[k].maddr), 32'(exp_maddr));
            checkOutput({nm, ".m_wrdata"}, 32'(obs[k].mwd), 32'(exp_mwd));
            ef      = cal_valid[k][slot] && cal_fetch[k][slot];
            el      = cal_valid[k][slot] && !cal_fetch[k][slot];
            exp_frd = ef ? mem_data[k] : hold_f[k];
            exp_lrd = el ? mem_data[k] : hold_l[k];
            checkOutput({nm, ".fetch_rdvalid"}, 32'(obs[k].fv), 32'(ef));
            checkOutput({nm, ".ldst_rdvalid"}, 32'(obs[k].lv), 32'(el));
            checkOutput({nm, ".fetch_rddata"}, 32'(obs[k].frd), 32'(exp_frd));
            checkOutput({nm, ".ldst_rddata"}, 32'(obs[k].lrd), 32'(exp_lrd));
            hold_f[k] = exp_frd;
            hold_l[k] = exp_lrd;
         end
         cal_valid[k][slot] = 1'b0;
      end
      if (reset) begin
         streak = 0;
         for (int k = 0; k < 2; k++) begin
            hold_f[k] = 16'h0000;
            hold_l[k] = 16'h0000;
            for (int s = 0; s < 16; s++) cal_valid[k][s] = 1'b0;
         end
      end else begin
         if (exp_mrd) begin
            for (int k = 0; k < 2; k++) begin
               cal_valid[k][(cyc + lat[k]) % 16] = 1'b1;
               cal_fetch[k][(cyc + lat[k]) % 16] = fg;
            end
         end
         if (fg || !fr)                  streak = 0;
         else if (lg && streak < MAX_RUN) streak++;
      end
      prev_fw = exp_fw;
      prev_lw = exp_lw;
   endtask

   initial begin
      int mode;
      reset       = 1'b1;
      fetch_rd    = 1'b0;
      fetch_addr  = 16'h0000;
      ldst_rd     = 1'b0;
      ldst_wr     = 1'b0;
      ldst_addr   = 16'h0000;
      ldst_wrdata = 16'h0000;
      mem_data[0] = 16'h0000;
      mem_data[1] = 16'h0000;
      for (int k = 0; k < 2; k++) begin
         hold_f[k] = 16'h0000;
         hold_l[k] = 16'h0000;
      end
      $display("[TB] start: %0d cycles, latencies 1 and 3, MAX_LDST_RUN=%0d", NCYC, MAX_RUN);
      for (int c = 0; c < NCYC; c++) begin
         @(posedge clk);
         #1;
         cyc = c;
         if (c < 3)                     mode = 3;
         else if (c < 300)              mode = 0;
         else if (c < 400)              mode = 1;
         else if (c < 499)              mode = 2;
         else if (c == 499)             mode = 3;
         else if (c == 500)             mode = 2;
         else if (c == 501)             mode = 3;
         else                           mode = 0;
         reset = (c < 3) || (c == 501) ||
                 (mode == 0 && $urandom_range(0, 59) == 0);
         applyStimulus(mode);
         #1;
         modelCycle();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
